// File: rtl/onewire_seq.sv
// Command sequencer for a 1-wire bit engine: turns RESET / byte / single-bit commands into slot writes and polls.
// Define ONEWIRE_SEQ_CRC_EN to add a running Dallas CRC-8 over byte traffic on output port crc.
module onewire_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic        cmd_ovd,
    input  logic [7:0]  cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_data,
    output logic        busy,
    output logic        ow_read,
    output logic        ow_write,
    output logic [31:0] ow_writedata,
    input  logic [31:0] ow_readdata,
    input  logic        ow_waitrequest
`ifdef ONEWIRE_SEQ_CRC_EN
    ,
    output logic [7:0]  crc
`endif
);

    localparam logic [1:0] OP_RESET = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    typedef enum logic [2:0] {IDLE, ISSUE, POLL, NEXT, RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_op;
    logic        r_ovd;
    logic [7:0]  r_data;
    logic [3:0]  r_cnt;
    logic        r_drx;
    logic        w_dtx;
    logic        w_rst_bit;
    logic        w_slot_done;
    logic        w_unused_rd;

    assign w_slot_done = !ow_waitrequest && ow_readdata[4];
    assign w_unused_rd = ^{ow_readdata[31:5], ow_readdata[2:0]};
    assign busy        = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Data register doubles as transmit shifter (LSB out) and receive shifter (bus bit in at MSB).
    always_ff @(posedge clk) begin
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    r_op   <= cmd_op;
                    r_ovd  <= cmd_ovd;
                    r_data <= cmd_data;
                    r_cnt  <= (cmd_op == OP_WRITE || cmd_op == OP_READ) ? 4'd8 : 4'd1;
                end
            end
            POLL: begin
                if (w_slot_done) begin
                    r_drx <= ow_readdata[3];
                end
            end
            NEXT: begin
                r_data <= {r_drx, r_data[7:1]};
                r_cnt  <= r_cnt - 4'd1;
            end
            default: ;
        endcase
    end

`ifdef ONEWIRE_SEQ_CRC_EN
    logic [7:0] r_crc;

    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[0] ^ b;
        return {1'b0, c[7:1]} ^ (fb ? 8'h8C : 8'h00);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc <= 8'd0;
        end else if (r_state == NEXT) begin
            if (r_op == OP_RESET) begin
                r_crc <= 8'd0;
            end else if (r_op == OP_WRITE || r_op == OP_READ) begin
                r_crc <= crc8_step(r_crc, r_drx);
            end
        end
    end

    assign crc = r_crc;
`endif

    always_comb begin
        w_dtx     = 1'b0;
        w_rst_bit = 1'b0;
        case (r_op)
            OP_RESET: w_rst_bit = 1'b1;
            OP_READ:  w_dtx     = 1'b1;
            default:  w_dtx     = r_data[0];
        endcase
    end

    always_comb begin
        w_next       = r_state;
        cmd_ready    = 1'b0;
        rsp_valid    = 1'b0;
        rsp_data     = 8'd0;
        ow_read      = 1'b0;
        ow_write     = 1'b0;
        ow_writedata = 32'd0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_next = ISSUE;
                end
            end
            ISSUE: begin
                ow_write     = 1'b1;
                ow_writedata = {24'd0, 2'b00, 2'b00, 1'b0, w_dtx, w_rst_bit, r_ovd};
                if (!ow_waitrequest) begin
                    w_next = POLL;
                end
            end
            POLL: begin
                ow_read = 1'b1;
                if (w_slot_done) begin
                    w_next = NEXT;
                end
            end
            NEXT: begin
                w_next = (r_cnt == 4'd1) ? RESP : ISSUE;
            end
            RESP: begin
                rsp_valid = 1'b1;
                case (r_op)
                    OP_RESET: rsp_data = {7'd0, ~r_drx};
                    OP_WRITE,
                    OP_READ:  rsp_data = r_data;
                    default:  rsp_data = {7'd0, r_drx};
                endcase
                if (rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_onewire_seq.sv
// Bench for onewire_seq: a behavioural bit-engine responder plus scenario tasks checked against command-level expectations.
// CRC scenarios are included when ONEWIRE_SEQ_CRC_EN is defined.
module tb_onewire_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic        cmd_ovd = 1'b0;
    logic [7:0]  cmd_data = 8'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [7:0]  rsp_data;
    logic        busy;
    logic        ow_read;
    logic        ow_write;
    logic [31:0] ow_writedata;
    logic [31:0] ow_readdata = 32'd0;
    logic        ow_waitrequest = 1'b0;
`ifdef ONEWIRE_SEQ_CRC_EN
    logic [7:0]  crc;
`endif

    always #5 clk = ~clk;

    onewire_seq dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_ovd(cmd_ovd), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy), .ow_read(ow_read), .ow_write(ow_write),
        .ow_writedata(ow_writedata), .ow_readdata(ow_readdata),
        .ow_waitrequest(ow_waitrequest)
`ifdef ONEWIRE_SEQ_CRC_EN
        , .crc(crc)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;

    // Bit-engine responder state
    int          wait_cycles = 0;
    int          poll_delay = 0;
    int          stall = 0;
    int          polls = 0;
    bit          cur_drx = 1'b0;
    bit          drx_q[$];
    logic [31:0] wr_log[$];
    int          rd_cycles = 0;
    int          wr_cycles = 0;
    int          prot_err = 0;

    always @(negedge clk) begin
        if (ow_read && ow_write) prot_err++;
        if (ow_write) begin
            wr_cycles++;
            if (ow_writedata[31:3] != 29'd0) prot_err++;
            if (stall < wait_cycles) begin
                ow_waitrequest = 1'b1;
                stall++;
            end else begin
                ow_waitrequest = 1'b0;
                stall = 0;
                polls = 0;
                wr_log.push_back(ow_writedata);
                cur_drx = (drx_q.size() > 0) ? drx_q.pop_front() : 1'b1;
            end
            ow_readdata = $urandom;
        end else if (ow_read) begin
            rd_cycles++;
            if (stall < wait_cycles) begin
                ow_waitrequest = 1'b1;
                stall++;
                ow_readdata = $urandom;
            end else begin
                ow_waitrequest = 1'b0;
                stall = 0;
                polls++;
                if (polls > poll_delay)
                    ow_readdata = ($urandom & 32'hFFFF_FFE7) | 32'h10 | {28'd0, cur_drx, 3'd0};
                else
                    ow_readdata = $urandom & 32'hFFFF_FFEF;
            end
        end else begin
            ow_waitrequest = 1'($urandom_range(0, 1));
            ow_readdata = $urandom;
        end
    end

`ifdef ONEWIRE_SEQ_CRC_EN
    function automatic logic [7:0] crc8_bit(input logic [7:0] c, input logic b);
        logic [7:0] n;
        n = c >> 1;
        if (c[0] != b) n = n ^ 8'h8C;
        return n;
    endfunction
`endif

    task automatic send_cmd(input logic [1:0] op, input logic ovd, input logic [7:0] data);
        int t = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_ovd   = ovd;
        cmd_data  = data;
        while (cmd_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic [7:0] d, output bit ok);
        int t = 0;
        while (rsp_valid !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        ok = (rsp_valid === 1'b1);
        d  = rsp_data;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
        n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_chk++; if ({ow_read, ow_write} !== 2'b00) begin n_fail++; $display("FAIL reset_ow_rw got %b want 00", {ow_read, ow_write}); end
        n_chk++; if (ow_writedata !== 32'd0) begin n_fail++; $display("FAIL reset_writedata got %h want 0", ow_writedata); end
        n_chk++; if (rsp_data !== 8'd0) begin n_fail++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
`ifdef ONEWIRE_SEQ_CRC_EN
        n_chk++; if (crc !== 8'd0) begin n_fail++; $display("FAIL reset_crc got %h want 0", crc); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_reset_cmd();
        logic [7:0] d;
        bit ok;
        wait_cycles = 0; poll_delay = 2; stall = 0;
        drx_q.delete(); drx_q.push_back(1'b0);
        wr_log.delete(); rd_cycles = 0;
        send_cmd(2'b00, 1'b0, 8'h5A);
        get_rsp(d, ok);
        n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rstcmd_timeout got %b want 1", ok); end
        n_chk++; if (wr_log.size() !== 1) begin n_fail++; $display("FAIL rstcmd_nwrites got %0d want 1", wr_log.size()); end
        n_chk++; if (wr_log.size() > 0 && wr_log[0] !== 32'h2) begin n_fail++; $display("FAIL rstcmd_writedata got %h want 2", wr_log[0]); end
        n_chk++; if (d !== 8'h01) begin n_fail++; $display("FAIL rstcmd_presence got %h want 01", d); end
        n_chk++; if (rd_cycles !== 3) begin n_fail++; $display("FAIL rstcmd_reads got %0d want 3", rd_cycles); end
    endtask

    task automatic test_write_byte();
        logic [7:0] d;
        logic [7:0] b;
        bit ok;
        b = 8'hA5;
        wait_cycles = 0; poll_delay = 0; stall = 0;
        drx_q.delete();
        for (int i = 0; i < 8; i++) drx_q.push_back(b[i]);
        wr_log.delete(); rd_cycles = 0;
        send_cmd(2'b01, 1'b0, b);
        get_rsp(d, ok);
        n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL wbyte_timeout got %b want 1", ok); end
        n_chk++; if (wr_log.size() !== 8) begin n_fail++; $display("FAIL wbyte_nwrites got %0d want 8", wr_log.size()); end
        for (int i = 0; i < 8 && i < wr_log.size(); i++) begin
            n_chk++;
            if (wr_log[i] !== {29'd0, b[i], 2'b00}) begin
                n_fail++; $display("FAIL wbyte_slot%0d got %h want %h", i, wr_log[i], {29'd0, b[i], 2'b00});
            end
        end
        n_chk++; if (d !== 8'hA5) begin n_fail++; $display("FAIL wbyte_echo got %h want a5", d); end
        n_chk++; if (rd_cycles !== 8) begin n_fail++; $display("FAIL wbyte_reads got %0d want 8", rd_cycles); end
    endtask

    task automatic test_read_byte();
        logic [7:0] d;
        bit ok;
        int bad;
        bit seq[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int o = 0; o < 2; o++) begin
            wait_cycles = 0; poll_delay = o; stall = 0;
            drx_q.delete();
            for (int i = 0; i < 8; i++) drx_q.push_back(seq[i]);
            wr_log.delete();
            send_cmd(2'b10, 1'(o), 8'h00);
            get_rsp(d, ok);
            bad = (wr_log.size() == 8) ? 0 : 1;
            foreach (wr_log[i]) if (wr_log[i] !== (32'h4 | 32'(o))) bad++;
            n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rbyte_timeout ovd=%0d got %b want 1", o, ok); end
            n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL rbyte_writes ovd=%0d bad=%0d want 0", o, bad); end
            n_chk++; if (d !== 8'hA3) begin n_fail++; $display("FAIL rbyte_data ovd=%0d got %h want a3", o, d); end
        end
    endtask

    task automatic test_bit();
        logic [7:0] d;
        bit ok, dtx, drx, ovd;
        for (int k = 0; k < 4; k++) begin
            dtx = 1'($urandom); drx = 1'($urandom); ovd = 1'($urandom);
            wait_cycles = 0; poll_delay = $urandom_range(0, 2); stall = 0;
            drx_q.delete(); drx_q.push_back(drx);
            wr_log.delete();
            send_cmd(2'b11, ovd, {7'($urandom), dtx});
            get_rsp(d, ok);
            n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL bit_timeout got %b want 1", ok); end
            n_chk++;
            if (wr_log.size() !== 1 || wr_log[0] !== {29'd0, dtx, 1'b0, ovd}) begin
                n_fail++; $display("FAIL bit_write n=%0d got %h want %h", wr_log.size(), wr_log[0], {29'd0, dtx, 1'b0, ovd});
            end
            n_chk++; if (d !== {7'd0, drx}) begin n_fail++; $display("FAIL bit_rsp got %h want %h", d, {7'd0, drx}); end
        end
    endtask

    task automatic test_stall();
        int t = 0;
        wait_cycles = 4; poll_delay = 0; stall = 0;
        drx_q.delete(); drx_q.push_back(1'b1);
        wr_log.delete(); wr_cycles = 0; rd_cycles = 0;
        send_cmd(2'b11, 1'b0, 8'h01);
        while (rsp_valid !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1; cmd_op = 2'b00;
            n_chk++; if (rsp_data !== 8'h01) begin n_fail++; $display("FAIL stall_rsp_hold%0d got %h want 01", i, rsp_data); end
            n_chk++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL stall_cmd_ready%0d got %b want 0", i, cmd_ready); end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        n_chk++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL stall_rsp_valid got %b want 1", rsp_valid); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_chk++; if (wr_cycles !== 5) begin n_fail++; $display("FAIL stall_write_cycles got %0d want 5", wr_cycles); end
        n_chk++; if (rd_cycles !== 5) begin n_fail++; $display("FAIL stall_read_cycles got %0d want 5", rd_cycles); end
        repeat (3) @(negedge clk);
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stall_busy_after got %b want 0", busy); end
        n_chk++; if (wr_log.size() !== 1) begin n_fail++; $display("FAIL stall_ignored_cmd writes=%0d want 1", wr_log.size()); end
        wait_cycles = 0;
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic        ovd;
        logic [7:0]  data, drx, exp_rsp, d;
        logic [31:0] exp_wr[$];
        logic [7:0]  m_crc;
        bit          ok, dtx;
        int          nb, bad;
        m_crc = 8'd0;
        for (int k = 0; k < 40; k++) begin
            op   = (k == 0) ? 2'b00 : 2'($urandom_range(0, 3));
            ovd  = 1'($urandom);
            data = 8'($urandom);
            drx  = 8'($urandom);
            nb   = (op == 2'b01 || op == 2'b10) ? 8 : 1;
            case (op)
                2'b00:   exp_rsp = {7'd0, ~drx[0]};
                2'b11:   exp_rsp = {7'd0, drx[0]};
                default: exp_rsp = drx;
            endcase
            exp_wr.delete();
            for (int i = 0; i < nb; i++) begin
                case (op)
                    2'b00:   dtx = 1'b0;
                    2'b01:   dtx = data[i];
                    2'b10:   dtx = 1'b1;
                    default: dtx = data[0];
                endcase
                exp_wr.push_back({29'd0, dtx, (op == 2'b00), ovd});
            end
`ifdef ONEWIRE_SEQ_CRC_EN
            if (op == 2'b00) m_crc = 8'd0;
            else if (nb == 8) for (int i = 0; i < 8; i++) m_crc = crc8_bit(m_crc, drx[i]);
`endif
            wait_cycles = $urandom_range(0, 2); poll_delay = $urandom_range(0, 3); stall = 0;
            drx_q.delete();
            for (int i = 0; i < nb; i++) drx_q.push_back(drx[i]);
            wr_log.delete();
            send_cmd(op, ovd, data);
            n_chk++; if ({busy, cmd_ready} !== 2'b10) begin n_fail++; $display("FAIL rnd%0d_busy got %b want 10", k, {busy, cmd_ready}); end
            get_rsp(d, ok);
            bad = (wr_log.size() == nb) ? 0 : 1;
            for (int i = 0; i < nb && i < wr_log.size(); i++) if (wr_log[i] !== exp_wr[i]) bad++;
            n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_timeout got %b want 1", k, ok); end
            n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL rnd%0d_writes op=%0d bad=%0d want 0", k, op, bad); end
            n_chk++; if (d !== exp_rsp) begin n_fail++; $display("FAIL rnd%0d_rsp op=%0d got %h want %h", k, op, d, exp_rsp); end
`ifdef ONEWIRE_SEQ_CRC_EN
            n_chk++; if (crc !== m_crc) begin n_fail++; $display("FAIL rnd%0d_crc got %h want %h", k, crc, m_crc); end
`endif
        end
        wait_cycles = 0; poll_delay = 0;
    endtask

`ifdef ONEWIRE_SEQ_CRC_EN
    task automatic test_crc();
        logic [7:0] rom[8] = '{8'h02, 8'h1C, 8'hB8, 8'h01, 8'h00, 8'h00, 8'h00, 8'hA2};
        logic [7:0] d, b;
        bit ok;
        wait_cycles = 0; poll_delay = 0; stall = 0;
        drx_q.delete(); drx_q.push_back(1'b0);
        send_cmd(2'b00, 1'b0, 8'h00);
        get_rsp(d, ok);
        n_chk++; if (crc !== 8'h00) begin n_fail++; $display("FAIL crc_after_reset got %h want 00", crc); end
        for (int j = 0; j < 8; j++) begin
            b = rom[j];
            drx_q.delete();
            for (int i = 0; i < 8; i++) drx_q.push_back(b[i]);
            send_cmd(2'b10, 1'b0, 8'h00);
            get_rsp(d, ok);
            n_chk++; if (d !== b) begin n_fail++; $display("FAIL crc_rom%0d got %h want %h", j, d, b); end
            if (j == 6) begin
                n_chk++; if (crc !== 8'hA2) begin n_fail++; $display("FAIL crc_7th got %h want a2", crc); end
            end
            if (j == 7) begin
                n_chk++; if (crc !== 8'h00) begin n_fail++; $display("FAIL crc_8th got %h want 00", crc); end
            end
        end
    endtask
`endif

    task automatic test_mid_reset();
        int t = 0;
        int rc;
        int seen = 0;
        wait_cycles = 0; poll_delay = 0; stall = 0;
        drx_q.delete(); wr_log.delete();
        send_cmd(2'b10, 1'b0, 8'h00);
        while (!(ow_read === 1'b1 && wr_log.size() == 4) && t < 200) begin @(negedge clk); t++; end
        n_chk++; if (ow_read !== 1'b1) begin n_fail++; $display("FAIL midrst_reach_poll got %b want 1", ow_read); end
        rst = 1'b1;
        @(negedge clk);
        n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_cmd_ready got %b want 1", cmd_ready); end
        n_chk++; if ({rsp_valid, busy, ow_read, ow_write} !== 4'b0000) begin
            n_fail++; $display("FAIL midrst_outputs got %b want 0000", {rsp_valid, busy, ow_read, ow_write});
        end
`ifdef ONEWIRE_SEQ_CRC_EN
        n_chk++; if (crc !== 8'd0) begin n_fail++; $display("FAIL midrst_crc got %h want 0", crc); end
`endif
        rst = 1'b0;
        rc = rd_cycles;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen++;
        end
        n_chk++; if (rd_cycles !== rc) begin n_fail++; $display("FAIL midrst_no_reads got %0d want %0d", rd_cycles, rc); end
        n_chk++; if (wr_log.size() !== 4) begin n_fail++; $display("FAIL midrst_no_writes got %0d want 4", wr_log.size()); end
        n_chk++; if (seen !== 0) begin n_fail++; $display("FAIL midrst_no_rsp got %0d want 0", seen); end
    endtask

    task automatic test_protocol();
        n_chk++; if (prot_err !== 0) begin n_fail++; $display("FAIL protocol_violations got %0d want 0", prot_err); end
    endtask

    initial begin
        test_reset();
        test_random();
        test_reset_cmd();
        test_write_byte();
        test_read_byte();
        test_bit();
        test_stall();
`ifdef ONEWIRE_SEQ_CRC_EN
        test_crc();
`endif
        test_mid_reset();
        test_protocol();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired after %0d checks, want completion", n_chk);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/onewire_seq.md
ONEWIRE_SEQ -- requirements
Module: onewire_seq

Interface
REQ-001 SHALL have port clk, input, 1, single clock for all logic.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port cmd_valid, input, 1, command request.
REQ-004 SHALL have port cmd_ready, output, 1, command accepted when cmd_valid & cmd_ready.
REQ-005 SHALL have port cmd_op, input, 2, command: 00 RESET, 01 WRITE_BYTE, 10 READ_BYTE, 11 BIT.
REQ-006 SHALL have port cmd_ovd, input, 1, overdrive timing for every slot of the command.
REQ-007 SHALL have port cmd_data, input, 8, byte for WRITE_BYTE; bit 0 for BIT.
REQ-008 SHALL have port rsp_valid, output, 1, response available; held until rsp_ready.
REQ-009 SHALL have port rsp_ready, input, 1, response consumed when rsp_valid & rsp_ready.
REQ-010 SHALL have port rsp_data, output, 8, result byte or bit.
REQ-011 SHALL have port busy, output, 1, high from command acceptance until response consumed.
REQ-012 SHALL have ports ow_read (output, 1), ow_write (output, 1), ow_writedata (output, 32), ow_readdata (input, 32), ow_waitrequest (input, 1): master port to the 1-wire bit engine.
REQ-013 SHALL have port crc, output, 8, running CRC-8 (present only with ONEWIRE_SEQ_CRC_EN).

Function
REQ-014 SHALL use FSM states IDLE, ISSUE, POLL, NEXT, RESP.
REQ-015 IDLE: cmd_ready=1; on handshake latch op/ovd/data, load bit counter (RESET/BIT: 1 slot, bytes: 8 slots), go ISSUE.
REQ-016 ISSUE: ow_write=1 with ow_writedata = {24'd0, 2'b00, 2'b00, 1'b0, dtx, rst_bit, ovd}; stay while ow_waitrequest=1, else go POLL.
REQ-017 dtx SHALL be: RESET 0 (rst_bit=1); WRITE_BYTE current LSB-first data bit; READ_BYTE 1; BIT cmd_data[0].
REQ-018 POLL: ow_read=1 each cycle; transfer completes when ow_waitrequest=0; on completed read with ow_readdata[4]=1 capture drx=ow_readdata[3], go NEXT; else keep polling.
REQ-019 NEXT: shift data register right, MSB <= drx; decrement counter; if counter reaches 0 go RESP, else go ISSUE.
REQ-020 RESP: rsp_valid=1; rsp_data = RESET {7'd0, ~drx} (presence); READ_BYTE shifted byte; WRITE_BYTE shifted-in echo of bus bits; BIT {7'd0, drx}.
REQ-021 RESP: go IDLE on rsp_ready; rsp_data stable while rsp_valid=1 and rsp_ready=0.
REQ-022 ow_read and ow_write SHALL never be asserted together and SHALL be low in IDLE, NEXT, RESP.
REQ-023 cmd_ready SHALL be 0 in all states except IDLE; cmd_valid outside IDLE ignored.
REQ-024 Minimum per slot: 1 ISSUE + 1 POLL + 1 NEXT cycle; WRITE_BYTE issues exactly 8 writes.
REQ-025 Interrupt enable bits (writedata[7:6]) SHALL always be written 0.

Reset
REQ-026 On rst: state IDLE, cmd_ready=1 the following cycle, rsp_valid=0, busy=0, ow_read=0, ow_write=0, ow_writedata=0, rsp_data=0, crc=0.
REQ-027 rst mid-command SHALL abandon the command without response; bit engine not touched.

Configuration
REQ-028 Macro ONEWIRE_SEQ_CRC_EN defined: crc port present; per bit of WRITE_BYTE/READ_BYTE (in NEXT) fb=crc[0]^bit, crc={1'b0,crc[7:1]} ^ (fb ? 8'h8C : 0); RESET op clears crc to 0; BIT op leaves crc unchanged.
REQ-029 Macro undefined: no crc port, no CRC logic; all other behaviour identical.

Verification
REQ-030 RESET, bench model returns ow_readdata[4:3]=2'b10 on 3rd poll -> ow_writedata=0x02, rsp_data=0x01 (presence), 3 ow_read cycles.
REQ-031 WRITE_BYTE 0xA5, immediate completion -> 8 writes with dtx sequence 1,0,1,0,0,1,0,1; drx echo -> rsp_data=0xA5.
REQ-032 READ_BYTE, model drx sequence 1,1,0,0,0,1,0,1 -> every write 0x04 (or 0x05 with cmd_ovd=1), rsp_data=0xA3.
REQ-033 ow_waitrequest=1 for 4 cycles during ISSUE and POLL -> ow_write/ow_read held, no state advance; rsp_ready=0 for 5 cycles -> rsp_data stable, cmd_ready=0.
REQ-034 CRC_EN: RESET then READ_BYTE x8 returning 0x02,0x1C,0xB8,0x01,0x00,0x00,0x00,0xA2 -> crc=0xA2 after 7th byte, 0x00 after 8th.
REQ-035 rst asserted in POLL of bit 3 -> next cycle IDLE, cmd_ready=1, rsp_valid=0, no further ow_read.
